frame_scheduler: RTL
====================

# frame_scheduler

Double-buffered frame scheduler for the 16×16 LED matrix scanner.
- A producer streams rows into a back buffer with a valid/ready handshake.
- The front buffer drives the 256-bit `mat` input of the display scanner.
- Front and back swap only on a scan boundary, and only after the current frame has been shown for a minimum dwell of full scans. This gives tear-free frame sequencing for the 3D display pipeline.

## Interface
Parameters:
- `ROWS`, 16, rows per frame (row index width `$clog2(ROWS)`).
- `COLS`, 16, bits per row word.
- `DWELL`, 64, minimum number of full scans a frame is shown before a swap (≥1).

Ports:
- `clock`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `wr_valid`  in  1  producer has a row word.
- `wr_ready`  out  1  scheduler accepts a row word this cycle.
- `wr_data`  in  `[0:COLS-1]`  row word; bit 0 = column 0.
- `wr_restart`  in  1  discard partial back-buffer fill; next accepted word is row 0.
- `scan_tick`  in  1  one-cycle pulse at the end of each full matrix scan.
- `frame`  out  `[0:ROWS*COLS-1]`  front frame; row r occupies bits `[r*COLS : r*COLS+COLS-1]`.
- `swap`  out  1  one-cycle pulse, registered, high the cycle after a swap edge.

## Operation
- Two banks, A and B, plus a `front_sel` pointer. `frame` is the bank selected by `front_sel`, taken directly from registers.
- State FILL:
  - `wr_ready`=1.
  - A handshake (`wr_valid & wr_ready`) writes `wr_data` into back-bank row `wr_idx`, then increments `wr_idx`.
  - Accepting row ROWS-1 sets `wr_idx`←0 and moves to PENDING.
- State PENDING:
  - `wr_ready`=0. `wr_valid` is ignored.
  - On `scan_tick` with `dwell_cnt` ≥ DWELL-1: toggle `front_sel`, set `dwell_cnt`←0, return to FILL.
  - Otherwise stay in PENDING.
- `dwell_cnt` increments on every `scan_tick` that is not a swap, saturating at DWELL-1. It counts in both states.
- `wr_restart` in FILL sets `wr_idx`←0. Rows already written are stale; they are overwritten before the next swap.
  - `wr_restart` has priority over a same-cycle handshake: that word is dropped.
  - `wr_restart` in PENDING is ignored. The completed frame stays committed.
- `scan_tick` in FILL never swaps. There is no partial-frame display.
- Handshake and swap never coincide, because `wr_ready`=0 in PENDING.

## Timing
- Reset values:
  - state=FILL, `wr_idx`=0, `front_sel`=A.
  - Both banks all-zero, so `frame`=0.
  - `wr_ready`=1 and `swap`=0 the cycle after reset.
  - `dwell_cnt`=DWELL-1 (saturated), so the first completed frame swaps at its first `scan_tick`.
- `wr_ready` is a function of the state register only, with no combinational path from `wr_valid`.
- Write latency: PENDING is entered the cycle after the ROWS-th handshake; `wr_ready` falls that cycle.
- Swap latency: `frame` changes and `swap`=1 in the cycle after the qualifying `scan_tick` edge.
- `wr_ready` rises in that same cycle, so back-to-back frames are possible.
- Reset mid-fill or mid-PENDING discards all buffered data and blanks `frame` immediately on the next edge.

## Configuration
- `FRAME_SCHED_UNDERRUN_EN` defined: adds output port `underrun` (out, 1). It is sticky.
  - Set when a `scan_tick` occurs in FILL while `dwell_cnt`=DWELL-1, meaning the producer missed its slot.
  - Cleared only by `reset`.
- Macro undefined: no `underrun` port and no associated logic.

## Structure
- Package `frame_sched_pkg` holds the shared definitions:
  - Constants `ROWS_DEF`=16, `COLS_DEF`=16, `DWELL_DEF`=64.
  - Typedef `row_t` (`logic [0:COLS_DEF-1]`).
  - State enum `sched_state_t` {FILL, PENDING}.
- Sub-module `frame_bank`: one ROWS×COLS register bank with a single row write port (`we`, `idx`, `data`), a synchronous clear on `reset`, and a flat `[0:ROWS*COLS-1]` read port. It is instantiated twice.
- The top level holds the FSM, `wr_idx`, `dwell_cnt`, `front_sel` and the output mux.

## Test plan
- Reset, then 16 handshakes with row r = 16'h0001<<r, then a `scan_tick` → `swap` pulses next cycle and `frame` shows a diagonal (bit `r*16+15-r` set).
- With DWELL=4: fill frame 1 and swap; fill frame 2 at once → no swap on ticks 1–3, swap exactly on tick 4.
- Keep `wr_valid` high through a full fill → `wr_ready` falls the cycle after the 16th accept; the 17th word is not consumed until after the swap.
- Write 5 rows, pulse `wr_restart` together with `wr_valid` → that word is dropped and `wr_idx`=0; 16 more words complete the frame, and the frame contains only those 16.
- Assert `reset` while in PENDING with a non-zero front frame → next cycle `frame`=0, `wr_ready`=1, the pending frame is lost and `swap` stays 0.
- `FRAME_SCHED_UNDERRUN_EN`: after dwell expires, issue a `scan_tick` with only 3 rows written → `underrun`=1 and stays set through later swaps until `reset`.

Source files
------------

// File: rtl/frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_sched_pkg
// Purpose  : Shared definitions for the double-buffered frame scheduler.
//            Default geometry and dwell, the row word type and the
//            scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package frame_sched_pkg;

    localparam int ROWS_DEF  = 16;
    localparam int COLS_DEF  = 16;
    localparam int DWELL_DEF = 64;

    // Row word: bit 0 is column 0.
    typedef logic [0:COLS_DEF-1] row_t;

    // FILL: back bank accepts rows. PENDING: a complete frame waits for a swap.
    typedef enum logic [0:0] {
        FILL    = 1'b0,
        PENDING = 1'b1
    } sched_state_t;

endpackage : frame_sched_pkg
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// ============================================================================
// Module   : frame_bank
// Purpose  : One ROWS x COLS register bank with a single row write port and a
//            flat read port. Cleared synchronously by reset.
// Ports    : clock   - system clock
//            reset   - synchronous active-high clear of every row
//            we      - write enable for row idx
//            idx     - row index to write
//            data    - row word, bit 0 = column 0
//            q       - whole bank, row r at bits [r*COLS : r*COLS+COLS-1]
// Revision : 1.0 - initial release
// ============================================================================
module frame_bank
    import frame_sched_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  we,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] idx,
    input  logic [0:COLS-1]                       data,
    output logic [0:ROWS*COLS-1]                  q
);

    localparam int c_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    // One register per row so each row decodes its own write enable.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic [c_IDX_W-1:0] c_ROW_IDX = c_IDX_W'(r);

        logic [0:COLS-1] r_row;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_row <= '0;
            end else if (we && (idx == c_ROW_IDX)) begin
                r_row <= data;
            end
        end

        assign q[r*COLS +: COLS] = r_row;
    end : g_row

endmodule : frame_bank
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Purpose  : Double-buffered frame scheduler for the LED matrix scanner.
//            A producer fills the back bank row by row over a valid/ready
//            handshake; the front bank drives the scanner. The banks swap
//            only on a scan_tick after the front frame has been shown for at
//            least DWELL full scans, giving tear-free frame sequencing.
// Ports    : clock      - system clock, posedge
//            reset      - synchronous active-high
//            wr_valid   - producer has a row word
//            wr_ready   - row word accepted this cycle (FILL only)
//            wr_data    - row word, bit 0 = column 0
//            wr_restart - restart back-bank fill at row 0 (FILL only)
//            scan_tick  - one-cycle pulse at the end of each full scan
//            frame      - front frame, row r at [r*COLS : r*COLS+COLS-1]
//            swap       - registered one-cycle pulse after a swap edge
//            underrun   - sticky: a scan ended in FILL after dwell expired
//                         (present only with FRAME_SCHED_UNDERRUN_EN)
// Options  : FRAME_SCHED_UNDERRUN_EN - adds the underrun output and logic
// Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [0:COLS-1]      wr_data,
    input  logic                 wr_restart,
    input  logic                 scan_tick,
    output logic [0:ROWS*COLS-1] frame,
    output logic                 swap
`ifdef FRAME_SCHED_UNDERRUN_EN
    ,
    output logic                 underrun
`endif
);

    localparam int c_IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(ROWS - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_MAX = c_DWELL_W'(DWELL - 1);

    sched_state_t           r_state;
    sched_state_t           w_state_next;
    logic [c_IDX_W-1:0]     r_wr_idx;
    logic [c_DWELL_W-1:0]   r_dwell_cnt;
    logic                   r_front_sel;   // 0 = bank A in front
    logic                   r_swap;

    logic                   w_accept;
    logic                   w_swap_edge;
    logic                   w_dwell_done;
    logic                   w_we_a;
    logic                   w_we_b;
    logic [0:ROWS*COLS-1]   w_bank_a;
    logic [0:ROWS*COLS-1]   w_bank_b;

    // ------------------------------------------------------------------
    // Handshake and swap qualification
    // ------------------------------------------------------------------
    // wr_ready depends on the state register only.
    assign wr_ready     = (r_state == FILL);
    assign w_dwell_done = (r_dwell_cnt == c_DWELL_MAX);

    // A restart in the same cycle drops the offered word.
    assign w_accept     = wr_valid && wr_ready && !wr_restart;
    assign w_swap_edge  = (r_state == PENDING) && scan_tick && w_dwell_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && (r_wr_idx == c_LAST_IDX)) begin
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (w_swap_edge) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Write index, dwell counter, front pointer, swap pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_idx <= '0;
        end else if (r_state == FILL) begin
            if (wr_restart) begin
                r_wr_idx <= '0;
            end else if (w_accept) begin
                r_wr_idx <= (r_wr_idx == c_LAST_IDX) ? '0 : r_wr_idx + 1'b1;
            end
        end
    end

    // Resets saturated so the very first completed frame swaps on its first
    // scan boundary instead of waiting out a dwell behind a blank frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dwell_cnt <= c_DWELL_MAX;
        end else if (w_swap_edge) begin
            r_dwell_cnt <= '0;
        end else if (scan_tick && !w_dwell_done) begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_front_sel <= 1'b0;
            r_swap      <= 1'b0;
        end else begin
            r_swap <= w_swap_edge;
            if (w_swap_edge) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    assign swap = r_swap;

    // ------------------------------------------------------------------
    // Banks: writes always land in the bank that is not in front.
    // ------------------------------------------------------------------
    assign w_we_a = w_accept &&  r_front_sel;
    assign w_we_b = w_accept && !r_front_sel;

    frame_bank #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bank_a (
        .clock (clock),
        .reset (reset),
        .we    (w_we_a),
        .idx   (r_wr_idx),
        .data  (wr_data),
        .q     (w_bank_a)
    );

    frame_bank #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bank_b (
        .clock (clock),
        .reset (reset),
        .we    (w_we_b),
        .idx   (r_wr_idx),
        .data  (wr_data),
        .q     (w_bank_b)
    );

    assign frame = r_front_sel ? w_bank_b : w_bank_a;

`ifdef FRAME_SCHED_UNDERRUN_EN
    // ------------------------------------------------------------------
    // Underrun: a scan ended while still filling although the dwell had
    // already expired, i.e. the producer missed its swap slot.
    // ------------------------------------------------------------------
    logic r_underrun;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (scan_tick && (r_state == FILL) && w_dwell_done) begin
            r_underrun <= 1'b1;
        end
    end

    assign underrun = r_underrun;
`endif

endmodule : frame_scheduler
`default_nettype wire
